// File: rtl/cache_ctrl_param_if.sv
// CPU/memory-side signal bundle for the cache controller.
// master = CPU/cache datapath side, slave = controller.
interface cache_ctrl_param_if;
    logic memtoreg;
    logic memwrite;
    logic hit;
    logic dirty;
    logic DM_WE;
    logic DM_RE;
    logic cache_we_word;
    logic cache_we_block;
    logic WriteData_Buffer;
    logic WritebackSignal;
    logic CacheLdFromBuffer;
    logic cache_dataReady;
    logic stall;

    // Requests are sampled only while the controller is idle. stall=1 means the
    // master must hold its request; a request is complete when stall is low.
    modport master (
        output memtoreg, memwrite, hit, dirty,
        input  DM_WE, DM_RE, cache_we_word, cache_we_block, WriteData_Buffer,
               WritebackSignal, CacheLdFromBuffer, cache_dataReady, stall
    );

    modport slave (
        input  memtoreg, memwrite, hit, dirty,
        output DM_WE, DM_RE, cache_we_word, cache_we_block, WriteData_Buffer,
               WritebackSignal, CacheLdFromBuffer, cache_dataReady, stall
    );
endinterface

// File: rtl/cache_ctrl_param.sv
// Blocking cache miss controller: writeback, block fill, buffered word write
// and optional write-around, with a parameterised memory transfer latency.
module cache_ctrl_param #(
    parameter int MEM_LATENCY = 3,
    parameter int CNT_W       = 4,
    parameter int WRITE_ALLOC = 1
) (
    input  logic               clk,
    input  logic               rst,
    cache_ctrl_param_if.slave  bus,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WBACK   = 3'd1,
        FILL    = 3'd2,
        WWORD   = 3'd3,
        WAROUND = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_wr_q, is_wr_d;
    logic             last;

    logic dm_we, dm_re, we_word, we_block, wdata_buf, wb_sig, ld_buf, data_rdy, stall;

    assign last    = (cnt_q == LAST_CNT);
    assign state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        dm_we     = 1'b0;
        dm_re     = 1'b0;
        we_word   = 1'b0;
        we_block  = 1'b0;
        wdata_buf = 1'b0;
        wb_sig    = 1'b0;
        ld_buf    = 1'b0;
        data_rdy  = 1'b0;
        stall     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Loads win over stores when both are requested.
                if (bus.memtoreg) begin
                    if (bus.hit) begin
                        data_rdy = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        wb_sig  = 1'b1;
                        is_wr_d = 1'b0;
                        state_d = bus.dirty ? WBACK : FILL;
                    end
                end else if (bus.memwrite) begin
                    if (bus.hit) begin
                        we_word = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        wdata_buf = 1'b1;
                        is_wr_d   = 1'b1;
                        if (WRITE_ALLOC != 0) begin
                            wb_sig  = 1'b1;
                            state_d = bus.dirty ? WBACK : FILL;
                        end else begin
                            state_d = WAROUND;
                        end
                    end
                end
            end
            WBACK: begin
                stall = 1'b1;
                dm_we = 1'b1;
                if (last) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FILL: begin
                stall = 1'b1;
                dm_re = 1'b1;
                if (last) begin
                    cnt_d    = '0;
                    we_block = 1'b1;
                    data_rdy = !is_wr_q;
                    state_d  = is_wr_q ? WWORD : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WWORD: begin
                stall   = 1'b1;
                we_word = 1'b1;
                ld_buf  = 1'b1;
                state_d = IDLE;
            end
            WAROUND: begin
                stall = 1'b1;
                dm_we = 1'b1;
                if (last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset silences every output, including the input-driven IDLE decodes.
    assign bus.DM_WE             = dm_we     & ~rst;
    assign bus.DM_RE             = dm_re     & ~rst;
    assign bus.cache_we_word     = we_word   & ~rst;
    assign bus.cache_we_block    = we_block  & ~rst;
    assign bus.WriteData_Buffer  = wdata_buf & ~rst;
    assign bus.WritebackSignal   = wb_sig    & ~rst;
    assign bus.CacheLdFromBuffer = ld_buf    & ~rst;
    assign bus.cache_dataReady   = data_rdy  & ~rst;
    assign bus.stall             = stall     & ~rst;

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Bench for cache_ctrl_param: three configurations driven by directed requests,
// checked every cycle against a transaction-level sequence model.
module tb_cache_ctrl_param;

    localparam int B_WE   = 8;
    localparam int B_RE   = 7;
    localparam int B_WORD = 6;
    localparam int B_BLK  = 5;
    localparam int B_WDB  = 4;
    localparam int B_WBS  = 3;
    localparam int B_LD   = 2;
    localparam int B_DR   = 1;
    localparam int B_ST   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       in_rd[3];
    logic       in_wr[3];
    logic       in_hit[3];
    logic       in_dirty[3];
    logic [8:0] out_v[3];
    logic [2:0] dbg_state[3];
    logic [8:0] exp_q[3][$];
    logic [63:0] mask[9];

    cache_ctrl_param_if bus_a ();
    cache_ctrl_param_if bus_b ();
    cache_ctrl_param_if bus_c ();

    cache_ctrl_param #(.MEM_LATENCY(3), .CNT_W(4), .WRITE_ALLOC(1)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .state_o(dbg_state[0]));
    cache_ctrl_param #(.MEM_LATENCY(3), .CNT_W(4), .WRITE_ALLOC(0)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .state_o(dbg_state[1]));
    cache_ctrl_param #(.MEM_LATENCY(1), .CNT_W(4), .WRITE_ALLOC(1)) u_c (
        .clk(clk), .rst(rst), .bus(bus_c.slave), .state_o(dbg_state[2]));

    assign bus_a.memtoreg = in_rd[0];
    assign bus_a.memwrite = in_wr[0];
    assign bus_a.hit      = in_hit[0];
    assign bus_a.dirty    = in_dirty[0];
    assign bus_b.memtoreg = in_rd[1];
    assign bus_b.memwrite = in_wr[1];
    assign bus_b.hit      = in_hit[1];
    assign bus_b.dirty    = in_dirty[1];
    assign bus_c.memtoreg = in_rd[2];
    assign bus_c.memwrite = in_wr[2];
    assign bus_c.hit      = in_hit[2];
    assign bus_c.dirty    = in_dirty[2];

    assign out_v[0] = {bus_a.DM_WE, bus_a.DM_RE, bus_a.cache_we_word, bus_a.cache_we_block,
                       bus_a.WriteData_Buffer, bus_a.WritebackSignal, bus_a.CacheLdFromBuffer,
                       bus_a.cache_dataReady, bus_a.stall};
    assign out_v[1] = {bus_b.DM_WE, bus_b.DM_RE, bus_b.cache_we_word, bus_b.cache_we_block,
                       bus_b.WriteData_Buffer, bus_b.WritebackSignal, bus_b.CacheLdFromBuffer,
                       bus_b.cache_dataReady, bus_b.stall};
    assign out_v[2] = {bus_c.DM_WE, bus_c.DM_RE, bus_c.cache_we_word, bus_c.cache_we_block,
                       bus_c.WriteData_Buffer, bus_c.WritebackSignal, bus_c.CacheLdFromBuffer,
                       bus_c.cache_dataReady, bus_c.stall};

    function automatic int lat_of(input int i);
        return (i == 2) ? 1 : 3;
    endfunction

    function automatic bit alloc_of(input int i);
        return (i != 1);
    endfunction

    function automatic logic [8:0] bv(input int b);
        logic [8:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Miss model: the whole stall sequence after the IDLE miss cycle is queued at once.
    task automatic push_alloc(input int i, input bit is_rd, input bit d);
        int l;
        l = lat_of(i);
        if (d) for (int k = 0; k < l; k++) exp_q[i].push_back(bv(B_ST) | bv(B_WE));
        for (int k = 0; k < l - 1; k++) exp_q[i].push_back(bv(B_ST) | bv(B_RE));
        exp_q[i].push_back(bv(B_ST) | bv(B_RE) | bv(B_BLK) | (is_rd ? bv(B_DR) : 9'h0));
        if (!is_rd) exp_q[i].push_back(bv(B_ST) | bv(B_WORD) | bv(B_LD));
    endtask

    task automatic model_idle(input int i, output logic [8:0] e);
        e = '0;
        if (in_rd[i]) begin
            if (in_hit[i]) e = bv(B_DR);
            else begin
                e = bv(B_ST) | bv(B_WBS);
                push_alloc(i, 1'b1, in_dirty[i]);
            end
        end else if (in_wr[i]) begin
            if (in_hit[i]) e = bv(B_WORD);
            else if (alloc_of(i)) begin
                e = bv(B_ST) | bv(B_WDB) | bv(B_WBS);
                push_alloc(i, 1'b0, in_dirty[i]);
            end else begin
                e = bv(B_ST) | bv(B_WDB);
                for (int k = 0; k < lat_of(i); k++) exp_q[i].push_back(bv(B_ST) | bv(B_WE));
            end
        end
    endtask

    logic [8:0] cmp_e;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                exp_q[i].delete();
                cmp_e = '0;
            end else if (exp_q[i].size() > 0) begin
                cmp_e = exp_q[i].pop_front();
            end else begin
                model_idle(i, cmp_e);
            end
            checks++;
            if (out_v[i] !== cmp_e) begin
                errors++;
                $display("FAIL cmp_u%0d t=%0t: got %b expected %b", i, $time, out_v[i], cmp_e);
            end
            if (out_v[i][B_WE] && out_v[i][B_RE]) begin
                errors++;
                $display("FAIL dm_excl_u%0d t=%0t: got DM_WE=1 DM_RE=1 expected not both", i, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int i, input bit rd, input bit wr, input bit h, input bit d);
        in_rd[i]    = rd;
        in_wr[i]    = wr;
        in_hit[i]   = h;
        in_dirty[i] = d;
    endtask

    // Issues one request, scrambles inputs while busy, records per-cycle output masks.
    task automatic run_req(input int i, input bit rd, input bit wr, input bit h, input bit d,
                           input int exp_stall, input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        for (int b = 0; b < 9; b++) mask[b] = '0;
        set_in(i, rd, wr, h, d);
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            for (int b = 0; b < 9; b++) if (out_v[i][b]) mask[b][cyc] = 1'b1;
            if (!out_v[i][B_ST]) done = 1'b1;
            else n++;
            @(posedge clk);
            #1;
            if (cyc + 1 <= exp_stall)
                set_in(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                set_in(i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk({name, "_stall"}, 64'(n), 64'(exp_stall));
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no end of stimulus expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        for (int i = 0; i < 3; i++) set_in(i, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs_a", 64'(out_v[0]), 64'h0);
        chk("reset_outputs_c", 64'(out_v[2]), 64'h0);
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "rd_hit");
        chk("rd_hit_dr", mask[B_DR], 64'h2);
        chk("rd_hit_dm", mask[B_WE] | mask[B_RE], 64'h0);
        run_req(0, 1'b0, 1'b1, 1'b1, 1'b1, 0, "wr_hit");
        chk("wr_hit_word", mask[B_WORD], 64'h2);

        run_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 4, "clean_rd");
        chk("clean_rd_re", mask[B_RE], 64'h1C);
        chk("clean_rd_blk", mask[B_BLK], 64'h10);
        chk("clean_rd_dr", mask[B_DR], 64'h10);
        chk("clean_rd_wbs", mask[B_WBS], 64'h2);

        run_req(0, 1'b1, 1'b0, 1'b0, 1'b1, 7, "dirty_rd");
        chk("dirty_rd_we", mask[B_WE], 64'h1C);
        chk("dirty_rd_re", mask[B_RE], 64'hE0);
        chk("dirty_rd_dr", mask[B_DR], 64'h80);

        run_req(0, 1'b0, 1'b1, 1'b0, 1'b0, 5, "clean_wr");
        chk("clean_wr_word", mask[B_WORD], 64'h20);

        run_req(0, 1'b0, 1'b1, 1'b0, 1'b1, 8, "dirty_wr");
        chk("dirty_wr_we", mask[B_WE], 64'h1C);
        chk("dirty_wr_re", mask[B_RE], 64'hE0);
        chk("dirty_wr_blk", mask[B_BLK], 64'h80);
        chk("dirty_wr_word", mask[B_WORD], 64'h100);
        chk("dirty_wr_ld", mask[B_LD], 64'h100);
        chk("dirty_wr_wdb", mask[B_WDB], 64'h2);

        run_req(0, 1'b1, 1'b1, 1'b0, 1'b0, 4, "rd_wr_prio");
        chk("rd_wr_prio_dr", mask[B_DR], 64'h10);
        chk("rd_wr_prio_word", mask[B_WORD], 64'h0);

        run_req(1, 1'b0, 1'b1, 1'b0, 1'b1, 4, "waround");
        chk("waround_we", mask[B_WE], 64'h1C);
        chk("waround_blk", mask[B_BLK], 64'h0);
        chk("waround_wbs", mask[B_WBS], 64'h0);
        run_req(1, 1'b1, 1'b0, 1'b0, 1'b0, 4, "noalloc_rd");
        chk("noalloc_rd_dr", mask[B_DR], 64'h10);

        run_req(2, 1'b1, 1'b0, 1'b0, 1'b1, 3, "l1_dirty_rd");
        chk("l1_dirty_rd_we", mask[B_WE], 64'h4);
        chk("l1_dirty_rd_re", mask[B_RE], 64'h8);
        chk("l1_dirty_rd_dr", mask[B_DR], 64'h8);
        run_req(2, 1'b0, 1'b1, 1'b0, 1'b1, 4, "l1_dirty_wr");
        chk("l1_dirty_wr_word", mask[B_WORD], 64'h10);

        // Reset during the second FILL cycle of a clean read miss.
        set_in(0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_fill_re", 64'(out_v[0][B_RE]), 64'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("mid_fill_rst_outputs", 64'(out_v[0]), 64'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "post_rst_hit");
        chk("post_rst_hit_dr", mask[B_DR], 64'h2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_param.md
CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

Interface
REQ-001 Parameter MEM_LATENCY, default 3, memory cycles per block transfer; legal range 1 .. 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 4, width of the latency counter.
REQ-003 Parameter WRITE_ALLOC, default 1, write-miss policy: 1 = write-allocate (fill, then write word), 0 = write-around (memory write only).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 memtoreg  input  1  CPU load request.
REQ-007 memwrite  input  1  CPU store request.
REQ-008 hit  input  1  tag match for the current address.
REQ-009 dirty  input  1  victim line dirty.
REQ-010 DM_WE  output  1  data-memory write strobe (victim writeback or write-around).
REQ-011 DM_RE  output  1  data-memory read strobe (block fill).
REQ-012 cache_we_word  output  1  cache single-word write enable.
REQ-013 cache_we_block  output  1  cache whole-block write enable.
REQ-014 WriteData_Buffer  output  1  capture store data into the write buffer.
REQ-015 WritebackSignal  output  1  capture victim line into the writeback buffer.
REQ-016 CacheLdFromBuffer  output  1  cache word source = write buffer.
REQ-017 cache_dataReady  output  1  load data valid to CPU.
REQ-018 stall  output  1  CPU must hold the current request.

Function
REQ-019 FSM states: IDLE, WBACK, FILL, WWORD, WAROUND; counter cnt is CNT_W bits wide.
REQ-020 All outputs are combinational decodes of state, cnt, the latched request type and the IDLE-cycle inputs; no output is registered.
REQ-021 IDLE, both memtoreg and memwrite high: memtoreg takes priority; memwrite is ignored.
REQ-022 IDLE read hit: cache_dataReady=1 in the same cycle, stall=0, remain in IDLE.
REQ-023 IDLE write hit: cache_we_word=1 in the same cycle, stall=0, remain in IDLE.
REQ-024 IDLE read miss: stall=1 and WritebackSignal=1 for that cycle; latch type=read; next state WBACK if dirty, else FILL.
REQ-025 IDLE write miss: stall=1 and WriteData_Buffer=1 for that cycle; latch type=write.
- WRITE_ALLOC=1: WritebackSignal=1 in the same cycle; next state WBACK if dirty, else FILL.
- WRITE_ALLOC=0: WritebackSignal=0; next state WAROUND.
REQ-026 dirty is sampled only in the IDLE miss cycle; changes to dirty in any other state are ignored.
REQ-027 WBACK: DM_WE=1 every cycle, for exactly MEM_LATENCY cycles (cnt 0..MEM_LATENCY-1); in the last cycle cnt clears and the next state is FILL.
REQ-028 FILL: DM_RE=1 for exactly MEM_LATENCY cycles.
- In the last cycle: cache_we_block=1 and cnt clears.
- Latched read: cache_dataReady=1 in the last cycle, next state IDLE.
- Latched write: next state WWORD.
REQ-029 WWORD: one cycle; cache_we_word=1 and CacheLdFromBuffer=1; next state IDLE.
REQ-030 WAROUND: DM_WE=1 for exactly MEM_LATENCY cycles; cache_we_* stay 0; next state IDLE.
REQ-031 stall=1 in every non-IDLE state; stall=0 in the cycle the FSM is back in IDLE; memtoreg and memwrite are ignored outside IDLE.
REQ-032 Outputs not named active for a state are 0; DM_WE and DM_RE are never high in the same cycle.
REQ-033 cnt never wraps; MEM_LATENCY=1 produces single-cycle WBACK, FILL and WAROUND phases.
REQ-034 Miss latency in stall cycles (L=MEM_LATENCY):
- clean read: 1+L
- dirty read: 1+2L
- clean allocating write: 2+L
- dirty allocating write: 2+2L
- write-around: 1+L

Reset
REQ-035 While rst=1, all outputs are forced to 0 regardless of inputs.
REQ-036 rst=1 asynchronously sets state=IDLE, cnt=0 and latched type=read, including mid-WBACK, FILL or WAROUND; the abandoned transfer is not resumed.
REQ-037 The first rising clk edge after rst falls evaluates requests from IDLE.

Verification (MEM_LATENCY=3 unless stated)
REQ-038 Read hit: memtoreg=1, hit=1 -> cache_dataReady=1 in the same cycle, stall=0, no DM_* activity.
REQ-039 Clean read miss -> stall high for 4 cycles; DM_RE high in cycles 2-4; cache_we_block and cache_dataReady high in cycle 4 only.
REQ-040 Dirty write miss, WRITE_ALLOC=1 -> DM_WE cycles 2-4, DM_RE cycles 5-7, cache_we_block cycle 7, cache_we_word and CacheLdFromBuffer cycle 8; stall for 8 cycles.
REQ-041 Write miss, WRITE_ALLOC=0, dirty=1 -> DM_WE cycles 2-4, cache_we_block never high, WritebackSignal never high; stall for 4 cycles.
REQ-042 rst pulsed during FILL cycle 2 -> all outputs 0 immediately; after release, a read hit gives cache_dataReady=1 on the first cycle.
REQ-043 MEM_LATENCY=1, dirty read miss -> DM_WE cycle 2, DM_RE and cache_dataReady cycle 3; stall for 3 cycles.
